tone_scheduler: RTL
===================

// Module: tone_scheduler
// PURPOSE
//  Shares the single tone generator (Buzzer_CTL div input) between a melody source and a higher-priority alert source.
//  Sequences notes in beat units and inserts an articulation gap of silence between notes.
//  Preempts a melody note for an alert, then resumes the melody note's remaining beats.
//  Sits between note sources (ROM player, key-beep logic) and the tone generator feeding the I2S Speaker path.
// PARAMETERS
//  DIV_W    27        width of note divider values (matches Divider/Buzzer div)
//  BEAT_W   4         width of note duration field, in beats
//  BEAT_DIV 25000000  clk cycles per beat (0.25 s @100 MHz); must be >=2
//  GAP_CYC  2500000   clk cycles of silence after every finished note; must be >=1
// PORTS
//  clk        in   1       system clock, 100 MHz
//  rst        in   1       asynchronous reset, active-low
//  en         in   1       scheduler enable; low forces silence
//  mel_valid  in   1       melody note available
//  mel_div    in   DIV_W   melody note divider
//  mel_beats  in   BEAT_W  melody note length in beats
//  mel_ready  out  1       1-cycle pulse: melody note accepted
//  alt_req    in   1       alert request (level)
//  alt_div    in   DIV_W   alert note divider
//  alt_beats  in   BEAT_W  alert length in beats
//  alt_ack    out  1       1-cycle pulse: alert accepted
//  note_div   out  DIV_W   divider to tone generator; 0 while silent
//  mute       out  1       1 = silence (drives audio to 0)
//  busy       out  1       1 in PLAY_MEL/PLAY_ALT/GAP
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, note_div=0, mute=1, mel_ready=0, alt_ack=0, busy=0, suspended=0, counters=0.
//  - A beats value of 0 is treated as 1. remaining is BEAT_W bits wide. beat_cnt counts 0..BEAT_DIV-1.
//  - tick is asserted when beat_cnt==BEAT_DIV-1.
//  - States:
//    - IDLE: mute=1, note_div=0. Priority: alt_req > suspended melody > mel_valid.
//      - alt_req: load alt note, alt_ack=1 for 1 cycle, go to PLAY_ALT.
//      - suspended: reload saved div/remaining, clear suspended, go to PLAY_MEL. No mel_ready pulse.
//      - mel_valid: load mel note, mel_ready=1 for 1 cycle, go to PLAY_MEL.
//    - Load: note_div<=div, mute<=0, remaining<=beats, beat_cnt<=0. These take effect the cycle after the decision.
//    - PLAY_*: beat_cnt increments every cycle.
//      - On tick: if remaining==1, go to GAP; else decrement remaining and set beat_cnt=0.
//    - PLAY_MEL with alt_req=1 (checked before tick):
//      - Save note_div and remaining (undecremented, partial beat lost) and set suspended=1.
//      - Load the alert and pulse alt_ack the same cycle. No gap.
//    - PLAY_ALT ignores alt_req. The alert always plays to completion.
//    - GAP: mute=1, note_div=0, GAP_CYC cycles, then IDLE.
//  - Latency: request seen in IDLE -> sound (mute=0) 1 cycle later. Note length = beats*BEAT_DIV cycles exactly.
//  - Simultaneous alt_req and mel_valid in IDLE: alert wins. mel_ready stays 0 and the melody waits.
//  - alt_req held high after ack: retriggers on the next IDLE (after GAP). Sources must drop req on ack.
//  - en=0 in any state: next cycle IDLE, mute=1, note_div=0, suspended=0. No acks are issued while en=0.
//  - Reset asserted mid-note: immediate silence; all state is cleared asynchronously.
// STRUCTURE
//  - Shared package audio_pkg holds:
//    - state encoding (IDLE, PLAY_MEL, PLAY_ALT, GAP; 2 bits)
//    - DIV_W/BEAT_W defaults
//    - note divider constants (e.g. DO=191571)
//  - One sub-module: beat_timer (counter with tick/clear, parameterised BEAT_DIV). It also serves GAP_CYC as a second instance.
//  - The FSM and the save registers live in tone_scheduler.
// TESTING (bench: BEAT_DIV=10, GAP_CYC=3)
//  1. Reset then idle: mute=1, note_div=0, busy=0, no pulses for 100 cycles.
//  2. mel_valid, div=191571, beats=2:
//     - mel_ready pulse;
//     - note_div=191571, mute=0 for exactly 20 cycles;
//     - then 3 cycles mute;
//     - then IDLE.
//  3. alt_req and mel_valid raised together, alt beats=1: alt_ack first; alt sounds 10 cycles, gap 3; then mel_ready and melody plays.
//  4. Melody beats=3; alt_req (beats=1) at cycle 15 of the melody:
//     - alt sounds 10 cycles, then gap 3;
//     - melody resumes with remaining=2, i.e. 20 cycles;
//     - no second mel_ready pulse.
//  5. en dropped mid-melody: mute=1 and note_div=0 next cycle. Re-enable: the suspended note is not resumed and a new mel_valid is accepted.
//  6. beats=0 -> plays 1 beat (10 cycles). rst pulsed mid-note -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg
//  Shared definitions for the tone path: scheduler state encoding, default
//  field widths and divider values for the notes of the C-major scale.
//  No ports; imported by the scheduler, its interface and its bench.
package audio_pkg;

  localparam int DIV_W_DEFAULT  = 27;
  localparam int BEAT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY_MEL = 2'd1,
    ST_PLAY_ALT = 2'd2,
    ST_GAP      = 2'd3
  } sched_state_t;

  // Divider values for the tone generator (100 MHz clock).
  localparam int unsigned NOTE_DO = 191571;
  localparam int unsigned NOTE_MI = 151515;
  localparam int unsigned NOTE_SO = 127551;
  localparam int unsigned NOTE_LA = 113636;

endpackage

// File: rtl/tone_scheduler_if.sv
// tone_scheduler_if
//  Bundles the scheduler's request/acknowledge and tone-output signals.
//  master : note sources side (drives en, melody and alert requests,
//           observes acks and the tone outputs)
//  slave  : the scheduler itself
//  Signals:
//   en                            scheduler enable
//   mel_valid/mel_div/mel_beats   melody note offer, mel_ready accept pulse
//   alt_req/alt_div/alt_beats     alert request, alt_ack accept pulse
//   note_div/mute/busy            tone generator control and status
interface tone_scheduler_if #(
  parameter int DIV_W  = 27,
  parameter int BEAT_W = 4
);
  logic              en;
  logic              mel_valid;
  logic [DIV_W-1:0]  mel_div;
  logic [BEAT_W-1:0] mel_beats;
  logic              mel_ready;
  logic              alt_req;
  logic [DIV_W-1:0]  alt_div;
  logic [BEAT_W-1:0] alt_beats;
  logic              alt_ack;
  logic [DIV_W-1:0]  note_div;
  logic              mute;
  logic              busy;

  modport master (
    output en, mel_valid, mel_div, mel_beats, alt_req, alt_div, alt_beats,
    input  mel_ready, alt_ack, note_div, mute, busy
  );

  modport slave (
    input  en, mel_valid, mel_div, mel_beats, alt_req, alt_div, alt_beats,
    output mel_ready, alt_ack, note_div, mute, busy
  );
endinterface

// File: rtl/beat_timer.sv
// beat_timer
//  Free-running cycle counter 0..LIMIT-1 used for beat timing and for the
//  silence gap between notes.
//  Ports:
//   clk    in  clock
//   rst    in  asynchronous reset, active-low
//   clear  in  force the count back to 0 (wins over run)
//   run    in  count this cycle
//   tick   out high in the cycle the count sits at LIMIT-1 while running
module beat_timer #(
  parameter int unsigned LIMIT = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == CNT_W'(LIMIT - 1));

  // Wraps to 0 on tick so the next beat starts without help from the FSM.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tone_scheduler.sv
// tone_scheduler
//  Shares one tone generator between a melody source and a higher-priority
//  alert source. Notes last a whole number of beats and are followed by a
//  short silence. An alert preempts a playing melody note; the melody note's
//  remaining whole beats are replayed once the alert and its gap are done.
//  Ports:
//   clk   in  system clock
//   rst   in  asynchronous reset, active-low
//   bus   slave side of tone_scheduler_if (requests, acks, tone outputs)
module tone_scheduler
  import audio_pkg::*;
#(
  parameter int          DIV_W    = DIV_W_DEFAULT,
  parameter int          BEAT_W   = BEAT_W_DEFAULT,
  parameter int unsigned BEAT_DIV = 25000000,
  parameter int unsigned GAP_CYC  = 2500000
) (
  input logic             clk,
  input logic             rst,
  tone_scheduler_if.slave bus
);

  sched_state_t      state_q, state_d;
  logic [DIV_W-1:0]  note_div_q, note_div_d;
  logic              mute_q, mute_d;
  logic              busy_q, busy_d;
  logic              mel_ready_q, mel_ready_d;
  logic              alt_ack_q, alt_ack_d;
  logic [BEAT_W-1:0] remaining_q, remaining_d;
  logic              suspended_q, suspended_d;
  logic [DIV_W-1:0]  save_div_q, save_div_d;
  logic [BEAT_W-1:0] save_rem_q, save_rem_d;

  logic beat_clear, beat_run, beat_tick;
  logic gap_run, gap_tick;

  // A zero-length note still plays for one beat.
  function automatic logic [BEAT_W-1:0] norm_beats(input logic [BEAT_W-1:0] b);
    return (b == '0) ? BEAT_W'(1) : b;
  endfunction

  assign beat_run = (state_q == ST_PLAY_MEL) || (state_q == ST_PLAY_ALT);
  assign gap_run  = (state_q == ST_GAP);

  beat_timer #(.LIMIT(BEAT_DIV)) u_beat_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (beat_clear),
    .run   (beat_run),
    .tick  (beat_tick)
  );

  // Held at 0 outside GAP so every gap is exactly GAP_CYC cycles long.
  beat_timer #(.LIMIT(GAP_CYC)) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!gap_run),
    .run   (gap_run),
    .tick  (gap_tick)
  );

  always_comb begin
    state_d     = state_q;
    note_div_d  = note_div_q;
    mute_d      = mute_q;
    remaining_d = remaining_q;
    suspended_d = suspended_q;
    save_div_d  = save_div_q;
    save_rem_d  = save_rem_q;
    mel_ready_d = 1'b0;
    alt_ack_d   = 1'b0;
    beat_clear  = 1'b0;

    if (!bus.en) begin
      // Disabling drops everything, including a suspended melody note.
      state_d     = ST_IDLE;
      note_div_d  = '0;
      mute_d      = 1'b1;
      suspended_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          note_div_d = '0;
          mute_d     = 1'b1;
          if (bus.alt_req) begin
            state_d     = ST_PLAY_ALT;
            note_div_d  = bus.alt_div;
            mute_d      = 1'b0;
            remaining_d = norm_beats(bus.alt_beats);
            beat_clear  = 1'b1;
            alt_ack_d   = 1'b1;
          end else if (suspended_q) begin
            // Resume the interrupted note; its source was acked long ago.
            state_d     = ST_PLAY_MEL;
            note_div_d  = save_div_q;
            mute_d      = 1'b0;
            remaining_d = save_rem_q;
            beat_clear  = 1'b1;
            suspended_d = 1'b0;
          end else if (bus.mel_valid) begin
            state_d     = ST_PLAY_MEL;
            note_div_d  = bus.mel_div;
            mute_d      = 1'b0;
            remaining_d = norm_beats(bus.mel_beats);
            beat_clear  = 1'b1;
            mel_ready_d = 1'b1;
          end
        end

        ST_PLAY_MEL, ST_PLAY_ALT: begin
          if ((state_q == ST_PLAY_MEL) && bus.alt_req) begin
            // Preempt: keep the undecremented beat count, so the partial
            // beat already played is simply lost on resume.
            save_div_d  = note_div_q;
            save_rem_d  = remaining_q;
            suspended_d = 1'b1;
            state_d     = ST_PLAY_ALT;
            note_div_d  = bus.alt_div;
            remaining_d = norm_beats(bus.alt_beats);
            beat_clear  = 1'b1;
            alt_ack_d   = 1'b1;
          end else if (beat_tick) begin
            if (remaining_q == BEAT_W'(1)) begin
              state_d    = ST_GAP;
              note_div_d = '0;
              mute_d     = 1'b1;
            end else begin
              remaining_d = remaining_q - BEAT_W'(1);
            end
          end
        end

        ST_GAP: begin
          note_div_d = '0;
          mute_d     = 1'b1;
          if (gap_tick) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          note_div_d = '0;
          mute_d     = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      note_div_q  <= '0;
      mute_q      <= 1'b1;
      busy_q      <= 1'b0;
      mel_ready_q <= 1'b0;
      alt_ack_q   <= 1'b0;
      remaining_q <= '0;
      suspended_q <= 1'b0;
      save_div_q  <= '0;
      save_rem_q  <= '0;
    end else begin
      state_q     <= state_d;
      note_div_q  <= note_div_d;
      mute_q      <= mute_d;
      busy_q      <= busy_d;
      mel_ready_q <= mel_ready_d;
      alt_ack_q   <= alt_ack_d;
      remaining_q <= remaining_d;
      suspended_q <= suspended_d;
      save_div_q  <= save_div_d;
      save_rem_q  <= save_rem_d;
    end
  end

  assign bus.note_div  = note_div_q;
  assign bus.mute      = mute_q;
  assign bus.busy      = busy_q;
  assign bus.mel_ready = mel_ready_q;
  assign bus.alt_ack   = alt_ack_q;

endmodule
